// File: rtl/uart_pkg.sv
// Shared types for the configurable UART transmitter: FSM state encoding and frame sizing.
// Parity support is controlled by the UART_TX_PARITY_EN macro.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Total bit periods in one frame: start + payload + optional parity + stop.
  function automatic int frame_bits(int data_bits, int stop_bits, bit parity);
    return 1 + data_bits + (parity ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Host-side write port and status bundle of the UART transmitter.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
);
  logic                          en;
  logic [DATA_BITS-1:0]          data;
  logic                          tx;
  logic                          busy;
  logic                          full;
  logic [$clog2(FIFO_DEPTH):0]   level;
  logic                          overflow;

  modport master (output en, data, input tx, busy, full, level, overflow);
  modport slave  (input en, data, output tx, busy, full, level, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// Power-of-two transmit FIFO; pointers wrap naturally, occupancy kept in an explicit counter.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter with configurable divider, payload and stop bits.
// Optional parity bit (and parity_odd port) compiled in with UART_TX_PARITY_EN.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
`ifdef UART_TX_PARITY_EN
  input  logic parity_odd,
`endif
  uart_tx_cfg_if.slave bus
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(CLK_DIV);
  localparam int FB = frame_bits(DATA_BITS, STOP_BITS, PARITY_EN);
  localparam int BW = $clog2(FB);

  tx_state_e            state, state_nxt;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] rdata;
  logic                 bit_end, pop, tx_bit, tx_q, ovf_q;
  logic                 full, empty;
  logic [LW-1:0]        level;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`endif

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.en),
    .pop   (pop),
    .wdata (bus.data),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bit_end      = (baud_cnt == CW'(CLK_DIV - 1));
  assign bus.tx       = tx_q;
  assign bus.full     = full;
  assign bus.level    = level;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state != IDLE) | ~empty;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_bit    = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        tx_bit = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx_bit = shreg[0];
        if (bit_end && bit_idx == BW'(DATA_BITS - 1))
          state_nxt = PARITY_EN ? PARITY : STOP;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_bit = par_bit;
        if (bit_end) state_nxt = STOP;
      end
`endif
      STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (bit_end && bit_idx == BW'(STOP_BITS - 1)) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx is registered from the current state, so the line trails the FSM by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_q     <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      tx_q  <= tx_bit;
      if (state == IDLE || bit_end) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + 1'b1;
      if (bit_end) bit_idx <= (state_nxt != state) ? '0 : bit_idx + 1'b1;
      if (pop)                           shreg <= rdata;
      else if (state == DATA && bit_end) shreg <= shreg >> 1;
      if (bus.en && full) ovf_q <= 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      par_bit <= 1'b0;
    else if (pop) par_bit <= (^rdata) ^ parity_odd;
  end
`endif
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench: occupancy/timing model feeds expected words, serial monitors decode and compare frames.
module tb_uart_tx_cfg;
  localparam int DIV = 4;
  localparam int DEP = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int F0 = (1 + 8 + PAR + 1) * DIV;
  localparam int F1 = (1 + 5 + PAR + 2) * DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic parity_odd = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_cfg_if #(.DATA_BITS(8), .FIFO_DEPTH(DEP)) b0 ();
  uart_tx_cfg_if #(.DATA_BITS(5), .FIFO_DEPTH(DEP)) b1 ();

  uart_tx_cfg #(.CLK_DIV(DIV), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(DEP)) dut0 (
    .clk (clk),
    .rst (rst),
`ifdef UART_TX_PARITY_EN
    .parity_odd (parity_odd),
`endif
    .bus (b0)
  );

  uart_tx_cfg #(.CLK_DIV(DIV), .DATA_BITS(5), .STOP_BITS(2), .FIFO_DEPTH(DEP)) dut1 (
    .clk (clk),
    .rst (rst),
`ifdef UART_TX_PARITY_EN
    .parity_odd (parity_odd),
`endif
    .bus (b1)
  );

  int unsigned expq0[$], expq1[$];
  int          starts0[$], starts1[$];
  int          done[2];
  logic [15:0] last_bits[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: condition not reached", name);
  endtask

  function automatic logic get_tx(input int id);
    return (id == 0) ? b0.tx : b1.tx;
  endfunction

  function automatic logic get_busy(input int id);
    return (id == 0) ? b0.busy : b1.busy;
  endfunction

  // Abstract model of DUT0: a frame occupies F0 cycles from the edge its word leaves the FIFO.
  int m_level = 0;
  int m_free_at = 0;
  bit m_ovf = 1'b0;

  always @(posedge clk) begin
    bit push, pop;
    int lv;
    if (rst) begin
      m_level = 0;
      m_free_at = 0;
      m_ovf = 1'b0;
      expq0.delete();
      expq1.delete();
    end else begin
      lv   = m_level;
      pop  = (lv > 0) && (cyc >= m_free_at);
      push = b0.en && (lv < DEP);
      if (b0.en && lv == DEP) m_ovf = 1'b1;
      if (push) expq0.push_back(int'(b0.data));
      if (pop) m_free_at = cyc + F0;
      m_level = lv + int'(push) - int'(pop);
      // DUT1 is only driven while idle, so every push is accepted.
      if (b1.en) expq1.push_back(int'(b1.data));
    end
  end

  always @(negedge clk) begin
    logic m_busy;
    if (!rst && chk_en) begin
      m_busy = (m_level > 0) || ((cyc - 1) < m_free_at);
      check("status", {25'd0, b0.busy, b0.full, b0.overflow, b0.level},
            {25'd0, m_busy, m_level == DEP, m_ovf, 3'(m_level)});
    end
  end

  // Serial decoder: every cycle of every bit is compared, so bit length errors show up too.
  task automatic monitor(input int id);
    int db, sb, nb;
    db = (id == 0) ? 8 : 5;
    sb = (id == 0) ? 1 : 2;
    nb = 1 + db + PAR + sb;
    forever begin
      @(negedge clk);
      if (!rst && get_tx(id) === 1'b0) begin
        int unsigned w;
        logic [15:0] exp_bits, got_bits;
        bit ok, aborted;
        w = 0;
        if (id == 0) starts0.push_back(cyc); else starts1.push_back(cyc);
        if (id == 0 && expq0.size() > 0) w = expq0.pop_front();
        else if (id == 1 && expq1.size() > 0) w = expq1.pop_front();
        else fail($sformatf("unexpected_frame%0d", id));
        exp_bits = '1;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < db; i++) exp_bits[1+i] = w[i];
        if (PAR != 0) exp_bits[1+db] = (^(w & ((32'd1 << db) - 1))) ^ parity_odd;
        got_bits = '1;
        ok = 1'b1;
        aborted = 1'b0;
        for (int b = 0; b < nb; b++) begin
          for (int k = 0; k < DIV; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (rst) begin
              aborted = 1'b1;
              break;
            end
            if (k == 0) got_bits[b] = get_tx(id);
            if (get_tx(id) !== exp_bits[b]) ok = 1'b0;
          end
          if (aborted) break;
        end
        if (!aborted) begin
          check($sformatf("frame_bits%0d", id), {16'd0, got_bits}, {16'd0, exp_bits});
          check($sformatf("bit_hold%0d", id), {31'd0, ok}, 32'd1);
          last_bits[id] = got_bits;
          done[id]++;
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic push0(input logic [7:0] d);
    b0.en = 1'b1;
    b0.data = d;
    @(negedge clk);
    b0.en = 1'b0;
  endtask

  task automatic wait_frames(input int id, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done[id] >= target) return;
      @(negedge clk);
    end
    fail($sformatf("frames_timeout%0d", id));
  endtask

  task automatic wait_idle(input int id, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (!get_busy(id)) begin
        at = cyc;
        return;
      end
      @(negedge clk);
    end
    fail($sformatf("idle_timeout%0d", id));
  endtask

  initial begin
    int c, at, d0, peak;
    bit saw_full;
    b0.en = 1'b0; b0.data = '0;
    b1.en = 1'b0; b1.data = '0;
    done[0] = 0; done[1] = 0;

    #1 rst = 1'b1;
    #2;
    check("rst_tx", {31'd0, b0.tx}, 32'd1);
    check("rst_busy", {31'd0, b0.busy}, 32'd0);
    check("rst_full", {31'd0, b0.full}, 32'd0);
    check("rst_level", {29'd0, b0.level}, 32'd0);
    check("rst_ovf", {31'd0, b0.overflow}, 32'd0);
    check("rst_tx1", {31'd0, b1.tx}, 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;

    // Single byte from idle
    c = cyc;
    push0(8'hA5);
    wait_idle(0, 200, at);
    check("t1_busy_fall", at - c, 2 + F0);
    check("t1_nframes", starts0.size(), 1);
    if (starts0.size() > 0) check("t1_start_lat", starts0[0] - c, 3);
    wait_frames(0, 1, 10);
`ifndef UART_TX_PARITY_EN
    check("t1_bits", {22'd0, last_bits[0][9:0]}, 32'h34A);
`endif

    // Back-to-back frames
    repeat (5) @(negedge clk);
    starts0.delete();
    d0 = done[0];
    push0(8'h01); push0(8'h02); push0(8'h03);
    wait_frames(0, d0 + 3, 400);
    check("t2_nframes", starts0.size(), 3);
    if (starts0.size() == 3) begin
      check("t2_gap1", starts0[1] - starts0[0], F0);
      check("t2_gap2", starts0[2] - starts0[1], F0);
    end

    // Overflow: six pushes into a depth-4 FIFO
    wait_idle(0, 200, at);
    d0 = done[0];
    peak = 0;
    saw_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push0(8'($urandom));
      if (int'(b0.level) > peak) peak = int'(b0.level);
      if (b0.full) saw_full = 1'b1;
    end
    check("t3_overflow", {31'd0, b0.overflow}, 32'd1);
    check("t3_peak", peak, DEP);
    check("t3_full", {31'd0, saw_full}, 32'd1);
    wait_frames(0, d0 + 5, 600);
    repeat (2 * F0) @(negedge clk);
    check("t3_frames", done[0] - d0, 5);

    // Reset in the middle of data bit 3
    d0 = done[0];
    c = starts0.size();
    push0(8'h5A);
    for (int i = 0; i < 100 && starts0.size() == c; i++) @(negedge clk);
    if (starts0.size() == c) fail("t4_start");
    else begin
      at = starts0[c];
      for (int i = 0; i < 100 && cyc < at + 17; i++) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t4_tx", {31'd0, b0.tx}, 32'd1);
      check("t4_level", {29'd0, b0.level}, 32'd0);
      check("t4_busy", {31'd0, b0.busy}, 32'd0);
      check("t4_ovf", {31'd0, b0.overflow}, 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      push0(8'h3C);
      wait_frames(0, d0 + 1, 200);
      check("t4_frames", done[0] - d0, 1);
    end

    // 5 data bits, 2 stop bits
    starts1.delete();
    c = cyc;
    b1.en = 1'b1; b1.data = 5'h1F;
    @(negedge clk);
    b1.en = 1'b0;
    wait_idle(1, 200, at);
    check("t5_busy_fall", at - c, 2 + F1);
    check("t5_nframes", starts1.size(), 1);
    if (starts1.size() > 0) check("t5_start_lat", starts1[0] - c, 3);
    wait_frames(1, 1, 10);
`ifndef UART_TX_PARITY_EN
    check("t5_bits", {24'd0, last_bits[1][7:0]}, 32'hFE);
`endif

`ifdef UART_TX_PARITY_EN
    wait_idle(0, 400, at);
    d0 = done[0];
    parity_odd = 1'b0;
    push0(8'h07);
    wait_frames(0, d0 + 1, 200);
    check("t6_even", {31'd0, last_bits[0][9]}, 32'd1);
    wait_idle(0, 200, at);
    parity_odd = 1'b1;
    push0(8'h07);
    wait_frames(0, d0 + 2, 200);
    check("t6_odd", {31'd0, last_bits[0][9]}, 32'd0);
    wait_idle(0, 200, at);
    parity_odd = 1'b0;
`endif

    // Random traffic: a dense burst phase that overflows, then a sparse phase
    for (int i = 0; i < 2500; i++) begin
      b0.en = (i < 1200) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 63) == 0);
      b0.data = 8'($urandom);
      @(negedge clk);
    end
    b0.en = 1'b0;
    wait_idle(0, (DEP + 2) * F0 + 50, at);
    repeat (2) @(negedge clk);
    check("drain_empty", expq0.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
